// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared MDOp encodings and MDU state type for the E-stage
//                multiply/divide unit, the decoder and the stall unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

   localparam int MD_OP_W = 4;

   typedef enum logic [MD_OP_W-1:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
      MD_MFLO  = 4'd8
   } md_op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // True for the four multi-cycle ops (mult/multu/div/divu)
   function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
      return (op >= MD_MULT) && (op <= MD_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_if
//  Description : E-stage <-> MDU signal bundle. The pipeline side is the
//                master, the MDU is the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if;
   import mdu_pkg::*;

   logic                 Req;
   logic [MD_OP_W-1:0]   MDOp;
   logic [31:0]          A;
   logic [31:0]          B;
   logic                 Busy;
   logic                 Start;
   logic [31:0]          HI;
   logic [31:0]          LO;
   logic [31:0]          MDOut;

   modport master (
      output Req, MDOp, A, B,
      input  Busy, Start, HI, LO, MDOut
   );

   modport slave (
      input  Req, MDOp, A, B,
      output Busy, Start, HI, LO, MDOut
   );

endinterface
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Fixed-latency multiply/divide unit holding HI/LO. Results
//                are computed at issue into temporaries and committed when
//                the latency counter expires; mthi/mtlo write in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  wire logic clk,
   input  wire logic reset,      // asynchronous, active-low
   mdu_if.slave      md
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   md_state_e          state_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        hi_q, lo_q;
   logic [31:0]        hi_tmp_q, lo_tmp_q, hi_tmp_d, lo_tmp_d;
   logic               commit_q, commit_d;
   logic               start;
   logic [63:0]        prod_s, prod_u;
   logic [31:0]        divisor, quot_s, rem_s, quot_u, rem_u;

   assign start = is_muldiv(md.MDOp) && !md.Req && (state_q == ST_IDLE);

   // Issue-time arithmetic; a zero divisor is replaced by 1 so the divider
   // never sees it (that result is discarded at commit anyway).
   always_comb begin
      divisor = (md.B == 32'd0) ? 32'd1 : md.B;
      prod_s  = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
      prod_u  = {32'd0, md.A} * {32'd0, md.B};
      if ((md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF)) begin
         quot_s = 32'h8000_0000;
         rem_s  = 32'd0;
      end else begin
         quot_s = $signed(md.A) / $signed(divisor);
         rem_s  = $signed(md.A) % $signed(divisor);
      end
      quot_u  = md.A / divisor;
      rem_u   = md.A % divisor;
   end

   // Select result, latency and commit enable for the op in E
   always_comb begin
      hi_tmp_d = 32'd0;
      lo_tmp_d = 32'd0;
      cnt_d    = '0;
      commit_d = 1'b0;
      case (md.MDOp)
         MD_MULT: begin
            hi_tmp_d = prod_s[63:32];
            lo_tmp_d = prod_s[31:0];
            cnt_d    = CNT_W'(MULT_CYCLES);
            commit_d = 1'b1;
         end
         MD_MULTU: begin
            hi_tmp_d = prod_u[63:32];
            lo_tmp_d = prod_u[31:0];
            cnt_d    = CNT_W'(MULT_CYCLES);
            commit_d = 1'b1;
         end
         MD_DIV: begin
            hi_tmp_d = rem_s;
            lo_tmp_d = quot_s;
            cnt_d    = CNT_W'(DIV_CYCLES);
            commit_d = (md.B != 32'd0);
         end
         MD_DIVU: begin
            hi_tmp_d = rem_u;
            lo_tmp_d = quot_u;
            cnt_d    = CNT_W'(DIV_CYCLES);
            commit_d = (md.B != 32'd0);
         end
         default: ;
      endcase
   end

   // Control FSM: issue, count down, commit; mthi/mtlo when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_tmp_q <= 32'd0;
         lo_tmp_q <= 32'd0;
         commit_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  hi_tmp_q <= hi_tmp_d;
                  lo_tmp_q <= lo_tmp_d;
                  commit_q <= commit_d;
                  cnt_q    <= cnt_d;
                  state_q  <= ST_BUSY;
               end else if (!md.Req) begin
                  if (md.MDOp == MD_MTHI) hi_q <= md.A;
                  if (md.MDOp == MD_MTLO) lo_q <= md.A;
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  if (commit_q) begin
                     hi_q <= hi_tmp_q;
                     lo_q <= lo_tmp_q;
                  end
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign md.Busy  = (state_q == ST_BUSY);
   assign md.Start = start;
   assign md.HI    = hi_q;
   assign md.LO    = lo_q;
   assign md.MDOut = (md.MDOp == MD_MFHI) ? hi_q :
                     (md.MDOp == MD_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire
